// File: rtl/pixel_unpacker.sv
// Unpacks 128-bit DDR words holding PIXELS_PER_WORD packed RGB pixels into a one-pixel-per-handshake stream.
// Optional pad-bit check enabled by defining PIXEL_UNPACKER_PAD_CHECK_EN.
module pixel_unpacker #(
  parameter int PIXEL_W         = 24,
  parameter int PIXELS_PER_WORD = 5,
  parameter int WORD_W          = 128,
  parameter int FRAME_PIXELS    = 786432
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               flush,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               pixel_last,
  output logic               frame_done,
  output logic               pad_error
);

  localparam int PIX_BITS = PIXELS_PER_WORD * PIXEL_W;
  localparam int IDX_W    = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam int CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_WORD - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  logic [PIX_BITS-1:0] word_q;
  logic                full_q;
  logic [IDX_W-1:0]    pix_idx;
  logic [CNT_W-1:0]    frame_cnt;
  logic [PIXEL_W-1:0]  slot [PIXELS_PER_WORD];

  logic pix_accept;
  logic buf_empties;
  logic word_accept;

  always_comb begin
    for (int unsigned k = 0; k < PIXELS_PER_WORD; k++) begin
      slot[k] = word_q[k*PIXEL_W +: PIXEL_W];
    end
  end

  // Output is a pure register mux: nothing from word_data reaches pixel_data.
  assign pixel_valid = full_q;
  assign pixel_data  = slot[pix_idx];
  assign pixel_last  = full_q && (frame_cnt == LAST_CNT);

  assign pix_accept  = full_q && pixel_ready && !flush;
  assign buf_empties = pix_accept && ((pix_idx == LAST_IDX) || pixel_last);
  // Refill in the same cycle the last pixel leaves, so the stream has no bubbles.
  assign word_ready  = !flush && (!full_q || buf_empties);
  assign word_accept = word_valid && word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      full_q     <= 1'b0;
      pix_idx    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      full_q     <= 1'b0;
      pix_idx    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_accept && pixel_last;
      if (pix_accept) begin
        frame_cnt <= pixel_last ? '0 : frame_cnt + 1'b1;
        if (buf_empties) begin
          full_q  <= 1'b0;
          pix_idx <= '0;
        end else begin
          pix_idx <= pix_idx + 1'b1;
        end
      end
      // A new word overrides the emptying update above.
      if (word_accept) begin
        word_q  <= word_data[PIX_BITS-1:0];
        full_q  <= 1'b1;
        pix_idx <= '0;
      end
    end
  end

`ifdef PIXEL_UNPACKER_PAD_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_error <= 1'b0;
    end else if (word_accept && (|word_data[WORD_W-1:PIX_BITS])) begin
      pad_error <= 1'b1;
`ifndef SYNTHESIS
      $error("pixel_unpacker: nonzero pad bits %0h", word_data[WORD_W-1:PIX_BITS]);
`endif
    end
  end
`else
  logic unused_pad;
  assign unused_pad = ^word_data[WORD_W-1:PIX_BITS];
  assign pad_error  = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench for pixel_unpacker with a 12-pixel frame so frame-end truncation is reachable.
module tb_pixel_unpacker;

  localparam int FP = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] word_data;
  logic         word_valid;
  logic         word_ready;
  logic         flush;
  logic [23:0]  pixel_data;
  logic         pixel_valid;
  logic         pixel_ready;
  logic         pixel_last;
  logic         frame_done;
  logic         pad_error;

  pixel_unpacker #(
    .PIXEL_W(24),
    .PIXELS_PER_WORD(5),
    .WORD_W(128),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .flush(flush),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_last(pixel_last),
    .frame_done(frame_done),
    .pad_error(pad_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] px;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int unsigned acc_cycles[$];
  int unsigned tests = 0;
  int unsigned errors = 0;
  int unsigned cycle = 0;
  int unsigned wacc_cycle = 0;
  int unsigned model_cnt = 0;
  logic        done_pend = 1'b0;
  logic        hold_pend = 1'b0;
  logic [23:0] prev_data = '0;
  logic        bp_en = 1'b0;
  int unsigned bp_ph = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Expected pixels of a word, truncated at the frame boundary.
  task automatic push_word(input logic [127:0] w);
    exp_t e;
    for (int unsigned k = 0; k < 5; k++) begin
      e.px   = w[k*24 +: 24];
      e.last = (model_cnt == FP - 1);
      q.push_back(e);
      if (e.last) begin
        model_cnt = 0;
        break;
      end
      model_cnt++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (reset) begin
      q.delete();
      model_cnt = 0;
      done_pend = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("pixel_valid", pixel_valid, q.size() != 0);
      check("frame_done", frame_done, done_pend);
      done_pend = 1'b0;
      if (hold_pend && pixel_valid) check("hold_data", pixel_data, prev_data);
      hold_pend = 1'b0;
      if (flush) begin
        q.delete();
        model_cnt = 0;
      end else begin
        if (pixel_valid && pixel_ready && q.size() != 0) begin
          e = q.pop_front();
          check("pixel_data", pixel_data, e.px);
          check("pixel_last", pixel_last, e.last);
          done_pend = e.last;
          acc_cycles.push_back(cycle);
        end else if (pixel_valid && !pixel_ready) begin
          check("ready_while_held", word_ready, 1'b0);
          hold_pend = 1'b1;
          prev_data = pixel_data;
        end
        if (word_valid && word_ready) begin
          wacc_cycle = cycle;
          push_word(word_data);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        pixel_ready = (bp_ph == 0);
        bp_ph = (bp_ph + 1) % 3;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [127:0] w);
    int unsigned n = 0;
    logic took = 1'b0;
    word_data  = w;
    word_valid = 1'b1;
    do begin
      @(negedge clk);
      took = word_ready;
      step();
      n++;
    end while (!took && n < 200);
    word_valid = 1'b0;
    if (!took) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((q.size() != 0 || pixel_valid) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("drain_timeout", 1'b0, 1'b1);
    step();
  endtask

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[127:120] = '0;
    return w;
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    word_data = '0;
    word_valid = 1'b0;
    flush = 1'b0;
    pixel_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_word_ready", word_ready, 1'b1);
    check("rst_pixel_valid", pixel_valid, 1'b0);
    check("rst_pixel_data", pixel_data, 24'h0);
    check("rst_pixel_last", pixel_last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pad_error", pad_error, 1'b0);

    // Single word, continuous ready.
    acc_cycles.delete();
    send_word(128'h00AAAAAABBBBBBCCCCCCDDDDDDEEEEEE);
    wait_idle();
    check("single_count", acc_cycles.size(), 5);
    if (acc_cycles.size() == 5) begin
      check("single_latency", acc_cycles[0], wacc_cycle + 1);
      check("single_span", acc_cycles[4] - acc_cycles[0], 4);
    end
    check("single_idle", pixel_valid, 1'b0);

    // Back-to-back from frame start: 5 + 5 + 2 (frame end) + 5 pixels.
    do_flush();
    acc_cycles.delete();
    for (int i = 0; i < 4; i++) send_word(rand_word());
    wait_idle();
    check("b2b_count", acc_cycles.size(), 17);
    if (acc_cycles.size() == 17) check("b2b_span", acc_cycles[16] - acc_cycles[0], 16);

    // Backpressure with ready pattern 1,0,0.
    bp_en = 1'b1;
    for (int i = 0; i < 3; i++) send_word(rand_word());
    wait_idle();
    bp_en = 1'b0;
    pixel_ready = 1'b1;

    // Flush after two pixels, then a full aligned frame.
    send_word(rand_word());
    step();
    step();
    do_flush();
    check("flush_valid", pixel_valid, 1'b0);
    for (int i = 0; i < 3; i++) send_word(rand_word());
    wait_idle();

    // Async reset after three pixels.
    send_word(rand_word());
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("areset_valid", pixel_valid, 1'b0);
    check("areset_data", pixel_data, 24'h0);
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    wait_idle();

    // Nonzero pad bits.
    begin
      logic [127:0] w;
      w = rand_word();
      w[127:120] = 8'h5A;
      send_word(w);
`ifdef PIXEL_UNPACKER_PAD_CHECK_EN
      check("pad_set", pad_error, 1'b1);
`else
      check("pad_ignored", pad_error, 1'b0);
`endif
      wait_idle();
      do_flush();
`ifdef PIXEL_UNPACKER_PAD_CHECK_EN
      check("pad_sticky", pad_error, 1'b1);
`else
      check("pad_tied", pad_error, 1'b0);
`endif
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Stream-side decoder for DDR pixel words. Each 128-bit word read from DDR holds 5 packed 24-bit RGB pixels; this block emits them one pixel per handshake.
- Sits between the memory handler's read-data path (ui_clk domain) and the frame BRAM writer / display pipeline.
- Enforces frame alignment: the last word of a frame carries only FRAME_PIXELS mod 5 valid pixels, and the remaining slots are discarded.

Parameters:
- PIXEL_W, 24, bits per pixel ({R,G,B}, 8 each).
- PIXELS_PER_WORD, 5, pixels packed per DDR word.
- WORD_W, 128, DDR word width. Bits [PIXELS_PER_WORD*PIXEL_W-1:0] carry pixels; the upper bits are pad.
- FRAME_PIXELS, 786432, pixels per frame (1024x768).

Ports:
- clk  input  1  ui_clk domain clock. All logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- word_data  input  WORD_W  packed DDR word. Pixel k occupies bits [k*PIXEL_W +: PIXEL_W], with pixel 0 = LSBs.
- word_valid  input  1  word_data valid.
- word_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort: clear buffer and counters.
- pixel_data  output  PIXEL_W  current pixel.
- pixel_valid  output  1  pixel_data valid.
- pixel_ready  input  1  downstream accepts pixel.
- pixel_last  output  1  pixel_data is the last pixel of the frame (qualified by pixel_valid).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
- pad_error  output  1  sticky pad-check flag (see Optional Feature).

Behaviour:
- Reset (async) values:
  - word buffer empty
  - pix_idx=0, frame_cnt=0
  - word_ready=1, pixel_valid=0, pixel_data=0, pixel_last=0, frame_done=0, pad_error=0
- State:
  - buffer register word_q plus flag full_q
  - pix_idx: 0..PIXELS_PER_WORD-1
  - frame_cnt: 0..FRAME_PIXELS-1, width $clog2(FRAME_PIXELS)
- Word accept: occurs when word_valid && word_ready. word_q <= word_data, full_q <= 1, pix_idx <= 0.
- Latency: a word accepted in cycle N gives pixel_valid=1 in cycle N+1.
- pixel_valid = full_q. pixel_data = word_q[pix_idx*PIXEL_W +: PIXEL_W]. The output is a mux from registers only, with no combinational path from word_data.
- pixel_last = full_q && (frame_cnt == FRAME_PIXELS-1).
- Pixel accept occurs when pixel_valid && pixel_ready:
  - frame_cnt increments, wrapping to 0 after FRAME_PIXELS-1.
  - If pix_idx == PIXELS_PER_WORD-1 or pixel_last: full_q <= 0 and pix_idx <= 0. Leftover slots of the word are discarded.
  - Otherwise pix_idx increments.
- word_ready = !full_q || (pixel accept that empties the buffer this cycle). This allows back-to-back words with a continuous pixel stream (1 pixel/cycle, no bubbles).
- Simultaneous word accept and emptying pixel accept in the same cycle: the new word is loaded, full_q stays 1, and pix_idx=0.
- frame_done: registered. It goes to 1 in the cycle after pixel_last is accepted, for exactly one cycle.
- pixel_valid && !pixel_ready: pixel_data, pix_idx and pixel_last hold stable. word_ready=0 while full_q=1.
- flush (synchronous, priority over all accepts):
  - full_q=0, pix_idx=0, frame_cnt=0, frame_done=0.
  - A word_valid presented during flush is not accepted: word_ready=0 in that cycle.
  - pad_error is not cleared.
- Reset asserted mid-word or mid-frame: immediate return to reset values. A partial frame is lost; the next accepted word is treated as pixel 0 of a new frame.
- No overflow is possible: input is backpressured via word_ready.

Optional Feature:
- Macro: PIXEL_UNPACKER_PAD_CHECK_EN.
- Defined: on each word accept, if word_data[WORD_W-1:PIXELS_PER_WORD*PIXEL_W] != 0, pad_error is set to 1. It stays 1 until reset. Each occurrence is also reported by $error in simulation.
- Undefined: pad bits are ignored, and pad_error is tied to 0.

Test Plan:
- Single word, continuous ready.
  - Stimulus: reset, then word 0x00AAAAAABBBBBBCCCCCCDDDDDDEEEEEE with pixel_ready=1.
  - Required: pixel_data EEEEEE, DDDDDD, CCCCCC, BBBBBB, AAAAAA on 5 consecutive cycles starting 1 cycle after accept. pixel_valid=0 afterwards.
- Back-to-back throughput.
  - Stimulus: 4 words presented continuously with pixel_ready=1.
  - Required: 20 pixels in 20 consecutive cycles. word_ready pulses high on every 5th pixel, with no bubble.
- Backpressure.
  - Stimulus: pixel_ready toggled 1,0,0,1,...
  - Required: pixel_data holds while ready=0, no pixel is skipped or duplicated, and word_ready=0 until the 5th pixel is accepted.
- Frame end with FRAME_PIXELS=12.
  - Stimulus: 3 words fed.
  - Required: 12 pixels out. pixel_last=1 on word2/pixel1. word2 slots 2-4 are discarded, frame_done pulses once, and the 4th word's pixel 0 starts frame_cnt=0.
- Flush and reset mid-word.
  - Stimulus: flush after 2 pixels of a word; separately, reset asserted asynchronously after 3 pixels.
  - Required: in both cases pixel_valid=0 next cycle (immediately for reset), frame_cnt=0, and the next word restarts at its pixel 0.
- Pad check (macro defined).
  - Stimulus: a word with [127:120]=0x5A.
  - Required: pad_error=1 one cycle after accept and stays 1 through flush. Pixels are still emitted normally.
